relu_seq_ctrl: RTL and testbench
================================

Name: relu_seq_ctrl

Overview:
- Sequencer for the 7-lane x 32-bit ReLU stage (224-bit word) of the RepVGG accelerator.
- On a start command it streams cfg_len words from the input feature buffer into the ReLU stage, then writes each result into the output buffer.
- It owns read issue, stage enable timing, write addressing, the hold (pause) interaction and completion signalling.
- The ReLU stage and both buffers are external; this block drives only their control and address lines.

Parameters:
- AW, 12, address width of both buffers and of the length field.
- RD_LAT, 1, input-buffer read latency in cycles (legal range 1..4).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle command strobe.
- cfg_rd_base  in  AW  first input-buffer address.
- cfg_wr_base  in  AW  first output-buffer address.
- cfg_len  in  AW  number of words to process.
- hold  in  1  pause new reads while high.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.
- rd_en  out  1  input-buffer read strobe.
- rd_addr  out  AW  input-buffer read address.
- relu_en  out  1  ReLU stage register enable.
- wr_en  out  1  output-buffer write strobe.
- wr_addr  out  AW  output-buffer write address.

Behaviour:
- Reset:
  - Synchronous: rst sampled high at a clk edge clears all outputs to 0, FSM to IDLE, counters and valid pipe to 0.
  - Reset mid-operation discards in-flight words. No wr_en occurs in the cycle after reset.
- FSM states: IDLE, ISSUE, DRAIN, FIN.
  - busy = 1 in ISSUE, DRAIN and FIN.
- IDLE:
  - start with cfg_len != 0: latch bases and length, go to ISSUE.
  - start with cfg_len == 0: go to FIN directly, with no reads and no writes.
  - start while busy is ignored, with no effect on the current command.
- ISSUE:
  - Each cycle with hold == 0: rd_en = 1, rd_addr = rd_base + issued, then issued++.
  - hold == 1: rd_en = 0, the issue counter is frozen, in-flight words continue.
  - When the last word issues (issued == len-1 and hold == 0), go to DRAIN next cycle.
- Valid pipe:
  - rd_en enters a shift register of depth RD_LAT+1.
  - relu_en = pipe[RD_LAT-1]: the cycle the buffer read data is presented to the ReLU stage.
  - wr_en = pipe[RD_LAT]: the cycle after relu_en, when the ReLU output register holds the result.
  - Latency: wr_en for a word follows its rd_en by exactly RD_LAT+1 cycles.
  - hold never stalls the pipe. The output buffer always accepts.
- Write addressing:
  - wr_addr = wr_base + written, presented in the same cycle as wr_en.
  - written increments on each wr_en.
- DRAIN:
  - rd_en = 0.
  - When written reaches len (last wr_en seen), go to FIN.
- FIN:
  - done = 1 for exactly one cycle, busy = 1.
  - Next state IDLE, busy = 0.
  - A start in the FIN cycle is ignored.
- Arithmetic:
  - Address sums are modulo 2^AW: wrap silently, no error.
  - issued and written are AW+1 bits so that cfg_len = 2^AW-1 terminates correctly.
- Simultaneous events:
  - hold rising in the same cycle the last word would issue blocks that issue; the FSM stays in ISSUE.
  - rst has priority over all other inputs.
- Ordering: writes occur in strictly ascending address order, with no gaps other than those caused by hold.

Decomposition:
- Package relu_seq_pkg:
  - State encoding constants (IDLE = 0, ISSUE = 1, DRAIN = 2, FIN = 3).
  - Default AW.
  - Maximum RD_LAT.
- Sub-module vld_pipe: parameterised-depth single-bit shift register with synchronous reset, taps at RD_LAT-1 and RD_LAT.

Test Plan:
- RD_LAT = 1, start with rd_base = 0x010, wr_base = 0x200, len = 4, hold = 0:
  - rd_en on cycles 1-4, addr 0x010-0x013.
  - relu_en on cycles 2-5.
  - wr_en on cycles 3-6, addr 0x200-0x203.
  - done on cycle 7.
- Same command with hold high on cycles 2-3:
  - Reads go to 0x010, then 0x011 resumes on cycle 4.
  - Writes show a 2-cycle gap.
  - Exactly 4 writes; done one cycle after the last write.
- cfg_len = 0:
  - No rd_en and no wr_en.
  - done pulses the cycle after IDLE->FIN, with busy high for 1 cycle.
- rd_base = 0xFFE, len = 4, AW = 12:
  - rd_addr sequence 0xFFE, 0xFFF, 0x000, 0x001.
  - wr_addr wraps likewise from wr_base = 0xFFF.
- start pulsed during ISSUE with different cfg values:
  - Ignored; the original 4 writes complete unchanged.
  - Separately, rst asserted 1 cycle after the 2nd rd_en: all outputs 0 the next cycle and no further writes.
- RD_LAT = 3, len = 2:
  - wr_en trails each rd_en by 4 cycles.
  - relu_en leads each wr_en by 1 cycle.

Source files
------------

// File: rtl/relu_seq_ctrl_pkg.sv
// Shared definitions for the ReLU-stage sequencer: state encoding, default
// address width and read-latency limits.
package relu_seq_pkg;

    localparam int unsigned DEF_AW     = 12;
    localparam int unsigned MAX_RD_LAT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_e;

    // Keeps the valid-pipe taps in range for out-of-range latency settings.
    function automatic int unsigned clamp_lat(input int unsigned lat);
        if (lat < 1)
            return 1;
        else if (lat > MAX_RD_LAT)
            return MAX_RD_LAT;
        else
            return lat;
    endfunction

endpackage

// File: rtl/relu_seq_ctrl_vld_pipe.sv
// Single-bit valid shift register tracking issued reads through the buffer
// read latency and the ReLU output register.
module vld_pipe
    import relu_seq_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic vld_i,
    output logic relu_o,
    output logic wr_o
);

    localparam int unsigned LAT   = clamp_lat(RD_LAT);
    localparam int unsigned DEPTH = LAT + 1;

    logic [DEPTH-1:0] pipe_q;
    logic [DEPTH-1:0] pipe_d;

    always_comb begin
        pipe_d = {pipe_q[DEPTH-2:0], vld_i};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign relu_o = pipe_q[LAT-1];
    assign wr_o   = pipe_q[LAT];

endmodule

// File: rtl/relu_seq_ctrl.sv
// Sequencer for the 7-lane ReLU stage: issues input-buffer reads, times the
// stage enable and writes results to the output buffer in ascending order.
module relu_seq_ctrl
    import relu_seq_pkg::*;
#(
    parameter int unsigned AW     = DEF_AW,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] cfg_rd_base,
    input  logic [AW-1:0] cfg_wr_base,
    input  logic [AW-1:0] cfg_len,
    input  logic          hold,
    output logic          busy,
    output logic          done,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    output logic          relu_en,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr
);

    localparam int unsigned CW = AW + 1;

    state_e        state_q, state_d;
    logic [AW-1:0] rd_base_q, rd_base_d;
    logic [AW-1:0] wr_base_q, wr_base_d;
    logic [AW-1:0] len_q, len_d;
    logic [CW-1:0] issued_q, issued_d;
    logic [CW-1:0] written_q, written_d;
    logic [CW-1:0] last_idx;

    // Counters are one bit wider than the length so a full 2^AW-1 run ends.
    assign last_idx = {1'b0, len_q} - CW'(1);

    always_comb begin
        state_d   = state_q;
        rd_base_d = rd_base_q;
        wr_base_d = wr_base_q;
        len_d     = len_q;
        issued_d  = issued_q;
        written_d = written_q;
        busy      = 1'b0;
        done      = 1'b0;
        rd_en     = 1'b0;

        if (wr_en) begin
            written_d = written_q + CW'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_len != '0) begin
                        rd_base_d = cfg_rd_base;
                        wr_base_d = cfg_wr_base;
                        len_d     = cfg_len;
                        issued_d  = '0;
                        written_d = '0;
                        state_d   = ISSUE;
                    end else begin
                        state_d   = FIN;
                    end
                end
            end
            ISSUE: begin
                busy = 1'b1;
                if (!hold) begin
                    rd_en    = 1'b1;
                    issued_d = issued_q + CW'(1);
                    if (issued_q == last_idx) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (wr_en && (written_q == last_idx)) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rd_base_q <= '0;
            wr_base_q <= '0;
            len_q     <= '0;
            issued_q  <= '0;
            written_q <= '0;
        end else begin
            state_q   <= state_d;
            rd_base_q <= rd_base_d;
            wr_base_q <= wr_base_d;
            len_q     <= len_d;
            issued_q  <= issued_d;
            written_q <= written_d;
        end
    end

    vld_pipe #(
        .RD_LAT (RD_LAT)
    ) u_vld_pipe (
        .clk_i  (clk),
        .rst_i  (rst),
        .vld_i  (rd_en),
        .relu_o (relu_en),
        .wr_o   (wr_en)
    );

    assign rd_addr = rd_base_q + issued_q[AW-1:0];
    assign wr_addr = wr_base_q + written_q[AW-1:0];

endmodule

// File: tb/tb_relu_seq_ctrl.sv
// Self-checking bench for relu_seq_ctrl: two instances (read latency 1 and 3)
// share stimulus and are compared each cycle against a timestamp-based model.
module tb_relu_seq_ctrl;

    localparam int AMOD = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        hold = 1'b0;
    logic [11:0] cfg_rd_base = '0;
    logic [11:0] cfg_wr_base = '0;
    logic [11:0] cfg_len = '0;

    logic [1:0]  busy_w, done_w, rd_w, relu_w, wr_w;
    logic [11:0] rda_w [2];
    logic [11:0] wra_w [2];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int lat [2] = '{1, 3};

    // Model: a command is a set of reads; each read k at cycle t yields
    // relu at t+lat, a write of wr_base+k at t+lat+1, done after the last write.
    bit m_cmd [2];
    int m_k [2], m_len [2], m_rb [2], m_wb [2], m_done [2];
    bit r_relu [2][16];
    bit r_wr [2][16];
    int r_wra [2][16];

    logic [11:0] sc_rb = '0, sc_wb = '0, sc_ln = '0;
    int foc = 0, s0 = 0, busy_cnt = 0;
    int q_rd[$], q_rda[$], q_relu[$], q_wr[$], q_wra[$], q_done[$];

    always #5 clk = ~clk;

    relu_seq_ctrl #(.AW(12), .RD_LAT(1)) u_dut0 (
        .clk(clk), .rst(rst), .start(start),
        .cfg_rd_base(cfg_rd_base), .cfg_wr_base(cfg_wr_base), .cfg_len(cfg_len),
        .hold(hold), .busy(busy_w[0]), .done(done_w[0]), .rd_en(rd_w[0]),
        .rd_addr(rda_w[0]), .relu_en(relu_w[0]), .wr_en(wr_w[0]), .wr_addr(wra_w[0])
    );

    relu_seq_ctrl #(.AW(12), .RD_LAT(3)) u_dut1 (
        .clk(clk), .rst(rst), .start(start),
        .cfg_rd_base(cfg_rd_base), .cfg_wr_base(cfg_wr_base), .cfg_len(cfg_len),
        .hold(hold), .busy(busy_w[1]), .done(done_w[1]), .rd_en(rd_w[1]),
        .rd_addr(rda_w[1]), .relu_en(relu_w[1]), .wr_en(wr_w[1]), .wr_addr(wra_w[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_q(input string nm, input int act[$], input int n,
                         input int e0, input int e1, input int e2, input int e3);
        int e [4];
        e = '{e0, e1, e2, e3};
        chk({nm, ".count"}, act.size(), n);
        for (int i = 0; i < n && i < 4; i++) begin
            chk($sformatf("%s[%0d]", nm, i), (i < act.size()) ? act[i] : -1, e[i]);
        end
    endtask

    task automatic begin_scen(input int f);
        foc = f;
        s0 = cyc;
        busy_cnt = 0;
        q_rd.delete(); q_rda.delete(); q_relu.delete();
        q_wr.delete(); q_wra.delete(); q_done.delete();
    endtask

    // One clock cycle: drive at negedge, compare at negedge+1, advance model.
    task automatic tick(input bit s, input bit h, input bit r);
        @(negedge clk);
        start = s; hold = h; rst = r;
        cfg_rd_base = sc_rb; cfg_wr_base = sc_wb; cfg_len = sc_ln;
        #1;
        for (int d = 0; d < 2; d++) begin
            int slot;
            int rel;
            bit e_busy, e_done, e_rd;
            int e_rda;
            slot   = cyc % 16;
            rel    = cyc - s0;
            e_busy = m_cmd[d];
            e_done = m_cmd[d] && (cyc == m_done[d]);
            e_rd   = m_cmd[d] && (m_k[d] < m_len[d]) && !h;
            e_rda  = (m_rb[d] + m_k[d]) % AMOD;
            chk($sformatf("d%0d busy c%0d", d, cyc), busy_w[d], e_busy);
            chk($sformatf("d%0d done c%0d", d, cyc), done_w[d], e_done);
            chk($sformatf("d%0d rd_en c%0d", d, cyc), rd_w[d], e_rd);
            chk($sformatf("d%0d relu_en c%0d", d, cyc), relu_w[d], r_relu[d][slot]);
            chk($sformatf("d%0d wr_en c%0d", d, cyc), wr_w[d], r_wr[d][slot]);
            if (e_rd)
                chk($sformatf("d%0d rd_addr c%0d", d, cyc), rda_w[d], e_rda);
            if (r_wr[d][slot])
                chk($sformatf("d%0d wr_addr c%0d", d, cyc), wra_w[d], r_wra[d][slot]);
            if (d == foc) begin
                if (rd_w[d] === 1'b1) begin q_rd.push_back(rel); q_rda.push_back(int'(rda_w[d])); end
                if (relu_w[d] === 1'b1) q_relu.push_back(rel);
                if (wr_w[d] === 1'b1) begin q_wr.push_back(rel); q_wra.push_back(int'(wra_w[d])); end
                if (done_w[d] === 1'b1) q_done.push_back(rel);
                if (busy_w[d] === 1'b1) busy_cnt++;
            end
            r_relu[d][slot] = 1'b0;
            r_wr[d][slot]   = 1'b0;
            if (r) begin
                m_cmd[d] = 1'b0;
                for (int k = 0; k < 16; k++) begin
                    r_relu[d][k] = 1'b0;
                    r_wr[d][k]   = 1'b0;
                end
            end else begin
                if (e_rd) begin
                    r_relu[d][(cyc + lat[d]) % 16]     = 1'b1;
                    r_wr[d][(cyc + lat[d] + 1) % 16]   = 1'b1;
                    r_wra[d][(cyc + lat[d] + 1) % 16]  = (m_wb[d] + m_k[d]) % AMOD;
                    m_k[d]++;
                    if (m_k[d] == m_len[d]) m_done[d] = cyc + lat[d] + 2;
                end
                if (e_done) m_cmd[d] = 1'b0;
                if (!e_busy && s) begin
                    m_cmd[d]  = 1'b1;
                    m_rb[d]   = int'(cfg_rd_base);
                    m_wb[d]   = int'(cfg_wr_base);
                    m_len[d]  = int'(cfg_len);
                    m_k[d]    = 0;
                    m_done[d] = (cfg_len == '0) ? cyc + 1 : -1;
                end
            end
        end
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk_all_zero(input string nm);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s d%0d ctl", nm, d),
                {27'd0, busy_w[d], done_w[d], rd_w[d], relu_w[d], wr_w[d]}, 32'd0);
            chk($sformatf("%s d%0d rd_addr", nm, d), rda_w[d], 32'd0);
            chk($sformatf("%s d%0d wr_addr", nm, d), wra_w[d], 32'd0);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_cmd[d] = 1'b0; m_k[d] = 0; m_len[d] = 0; m_done[d] = -1;
        end
        repeat (2) @(posedge clk);
        tick(1'b0, 1'b0, 1'b0);
        chk_all_zero("reset");
        run(2);

        // Basic command, no hold
        sc_rb = 12'h010; sc_wb = 12'h200; sc_ln = 12'd4;
        begin_scen(0);
        tick(1'b1, 1'b0, 1'b0);
        run(13);
        chk_q("s1 rd cyc", q_rd, 4, 1, 2, 3, 4);
        chk_q("s1 rd addr", q_rda, 4, 'h010, 'h011, 'h012, 'h013);
        chk_q("s1 relu cyc", q_relu, 4, 2, 3, 4, 5);
        chk_q("s1 wr cyc", q_wr, 4, 3, 4, 5, 6);
        chk_q("s1 wr addr", q_wra, 4, 'h200, 'h201, 'h202, 'h203);
        chk_q("s1 done cyc", q_done, 1, 7, 0, 0, 0);

        // Hold on cycles 2-3
        begin_scen(0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        run(11);
        chk_q("s2 rd cyc", q_rd, 4, 1, 4, 5, 6);
        chk_q("s2 rd addr", q_rda, 4, 'h010, 'h011, 'h012, 'h013);
        chk_q("s2 wr cyc", q_wr, 4, 3, 6, 7, 8);
        chk_q("s2 done cyc", q_done, 1, 9, 0, 0, 0);

        // Zero length
        sc_ln = 12'd0;
        begin_scen(0);
        tick(1'b1, 1'b0, 1'b0);
        run(5);
        chk("s3 rd count", q_rd.size(), 0);
        chk("s3 wr count", q_wr.size(), 0);
        chk_q("s3 done cyc", q_done, 1, 1, 0, 0, 0);
        chk("s3 busy cycles", busy_cnt, 1);

        // Address wrap
        sc_rb = 12'hFFE; sc_wb = 12'hFFF; sc_ln = 12'd4;
        begin_scen(0);
        tick(1'b1, 1'b0, 1'b0);
        run(13);
        chk_q("s4 rd addr", q_rda, 4, 'hFFE, 'hFFF, 'h000, 'h001);
        chk_q("s4 wr addr", q_wra, 4, 'hFFF, 'h000, 'h001, 'h002);

        // Start during ISSUE with different configuration
        sc_rb = 12'h010; sc_wb = 12'h200; sc_ln = 12'd4;
        begin_scen(0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        sc_rb = 12'h300; sc_wb = 12'h700; sc_ln = 12'd9;
        tick(1'b1, 1'b0, 1'b0);
        run(11);
        chk_q("s5 wr addr", q_wra, 4, 'h200, 'h201, 'h202, 'h203);
        chk_q("s5 done cyc", q_done, 1, 7, 0, 0, 0);

        // Reset one cycle after the second read
        sc_rb = 12'h010; sc_wb = 12'h200; sc_ln = 12'd4;
        begin_scen(0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        chk_all_zero("s5b after rst");
        run(8);
        chk_q("s5b wr cyc", q_wr, 1, 3, 0, 0, 0);
        chk("s5b done count", q_done.size(), 0);

        // Read latency 3, two words
        sc_rb = 12'h040; sc_wb = 12'h080; sc_ln = 12'd2;
        begin_scen(1);
        tick(1'b1, 1'b0, 1'b0);
        run(13);
        chk_q("s6 rd cyc", q_rd, 2, 1, 2, 0, 0);
        chk_q("s6 relu cyc", q_relu, 2, 4, 5, 0, 0);
        chk_q("s6 wr cyc", q_wr, 2, 5, 6, 0, 0);
        chk_q("s6 wr addr", q_wra, 2, 'h080, 'h081, 0, 0);
        chk_q("s6 done cyc", q_done, 1, 7, 0, 0, 0);

        // Maximum length
        sc_rb = 12'h123; sc_wb = 12'h456; sc_ln = 12'hFFF;
        begin_scen(0);
        tick(1'b1, 1'b0, 1'b0);
        run(4110);
        chk("s7 wr count", q_wr.size(), 4095);
        chk("s7 last wr addr", (q_wra.size() > 0) ? q_wra[q_wra.size()-1] : -1, 'h454);
        chk_q("s7 done cyc", q_done, 1, 4098, 0, 0, 0);

        // Randomised traffic against the model
        begin_scen(0);
        for (int i = 0; i < 1500; i++) begin
            bit s, h, r;
            s = ($urandom_range(0, 4) == 0);
            h = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 199) == 0);
            sc_rb = 12'($urandom_range(0, 4095));
            sc_wb = ($urandom_range(0, 1) == 0) ? 12'($urandom_range(4088, 4095))
                                                : 12'($urandom_range(0, 4095));
            sc_ln = 12'($urandom_range(0, 9));
            tick(s, h, r);
        end
        run(14);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
